// File: rtl/xtea_encipher_core.sv
// Iterative XTEA encipher engine. Each clock performs one full XTEA cycle,
// which is two Feistel half-rounds. A reset pulse clears the engine, and
// deasserting reset starts a new encipherment. all_done qualifies the outputs.
module xtea_encipher_core #(
  parameter int unsigned NUM_CYCLES = 32,
  parameter logic [31:0] DELTA      = 32'h9E3779B9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  data_in1,
  input  logic [31:0]  data_in2,
  input  logic [127:0] key_in,
  output logic [31:0]  data_out1,
  output logic [31:0]  data_out2,
  output logic         all_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_CYCLE = 6'(NUM_CYCLES - 1);

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   sum_q, sum_d;
  logic [31:0]   v0_q, v0_d;
  logic [31:0]   v1_q, v1_d;
  logic [127:0]  key_q, key_d;

  logic [31:0]   v0_rnd, sum_rnd, v1_rnd;

  // The Feistel mixing term ((v << 4) ^ (v >> 5)) + v, computed modulo 2^32.
  function automatic logic [31:0] mix(input logic [31:0] v);
    mix = ((v << 4) ^ (v >> 5)) + v;
  endfunction

  // Selects a key word. Word 0 is the most significant word of the key.
  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    case (idx)
      2'd0:    key_word = k[127:96];
      2'd1:    key_word = k[95:64];
      2'd2:    key_word = k[63:32];
      default: key_word = k[31:0];
    endcase
  endfunction

  // State register. An asynchronous reset aborts any run in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> LOAD -> ROUND (repeated) -> DONE, which then holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD:  state_d = S_ROUND;
      S_ROUND: if (cnt_q == LAST_CYCLE) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // One complete XTEA cycle. The second half-round uses the updated v0 and the updated sum.
  always_comb begin
    v0_rnd  = v0_q + (mix(v1_q) ^ (sum_q + key_word(key_q, sum_q[1:0])));
    sum_rnd = sum_q + DELTA;
    v1_rnd  = v1_q + (mix(v0_rnd) ^ (sum_rnd + key_word(key_q, sum_rnd[12:11])));
  end

  // Datapath next values. Inputs are captured only when leaving LOAD.
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    key_d = key_q;
    case (state_q)
      S_LOAD: begin
        v0_d  = data_in1;
        v1_d  = data_in2;
        key_d = key_in;
        sum_d = 32'd0;
        cnt_d = 6'd0;
      end
      S_ROUND: begin
        v0_d  = v0_rnd;
        v1_d  = v1_rnd;
        sum_d = sum_rnd;
        cnt_d = cnt_q + 6'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers. These are cleared on reset so that no partial result survives an abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v0_q  <= '0;
      v1_q  <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      key_q <= '0;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end

  // Outputs are driven from registers only. The words must be qualified by all_done.
  always_comb begin
    data_out1 = v0_q;
    data_out2 = v1_q;
    all_done  = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_xtea_encipher_core.sv
// Directed and randomized bench for xtea_encipher_core. It compares the core
// against a plain-arithmetic XTEA reference and against published result words.
module tb_xtea_encipher_core;

  localparam int unsigned NCYC    = 32;
  localparam int          LATENCY = NCYC + 2;

  logic         clock;
  logic         reset;
  logic [31:0]  data_in1, data_in2;
  logic [127:0] key_in;
  logic [31:0]  data_out1, data_out2;
  logic         all_done;

  int n_assert = 0;
  int n_fail   = 0;

  xtea_encipher_core #(.NUM_CYCLES(NCYC), .DELTA(32'h9E3779B9)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .key_in   (key_in),
    .data_out1(data_out1),
    .data_out2(data_out2),
    .all_done (all_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference XTEA encipher, written in the textbook loop form.
  function automatic logic [63:0] xtea_ref(input logic [127:0] key, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] k [4];
    logic [31:0] y, z, s;
    k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
    y = a; z = b; s = 32'd0;
    for (int i = 0; i < int'(NCYC); i++) begin
      y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + k[s & 32'd3]));
      s = s + 32'h9E3779B9;
      z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + k[(s >> 11) & 32'd3]));
    end
    return {y, z};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  // Counts edges until all_done rises. The wait is bounded.
  task automatic wait_done(input int start, output int edges);
    edges = start;
    while (!all_done && edges < 200) begin
      edge1();
      edges++;
    end
  endtask

  // Applies the inputs, pulses reset for one cycle, then runs to completion.
  task automatic do_run(input logic [127:0] k, input logic [31:0] a, input logic [31:0] b, output int edges);
    key_in = k; data_in1 = a; data_in2 = b;
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    wait_done(0, edges);
  endtask

  initial begin : stim
    int          edges;
    logic [63:0] exp, first;
    logic [127:0] rk;
    logic [31:0]  ra, rb;

    reset = 1'b0; key_in = '0; data_in1 = '0; data_in2 = '0;
    #2 reset = 1'b1;
    #1;
    chk("reset_done", 64'(all_done), 64'd0);
    chk("reset_out", {data_out1, data_out2}, 64'd0);

    // All-zero key and data: exact latency and the known result.
    do_run('0, 32'h0, 32'h0, edges);
    chk("zero_latency", 64'(edges), 64'(LATENCY));
    chk("zero_model", {data_out1, data_out2}, xtea_ref('0, 0, 0));
    chk("zero_const", {data_out1, data_out2}, 64'hdee9d4d8_f7131ed9);

    // Result is held, with all_done high, for 20 further cycles.
    do_run(128'h11111111222222223333333344444444, 32'h0, 32'h0, edges);
    first = {data_out1, data_out2};
    chk("k1_const", first, 64'hf07ac290_23c92672);
    chk("k1_model", first, xtea_ref(128'h11111111222222223333333344444444, 0, 0));
    for (int i = 0; i < 20; i++) begin
      edge1();
      chk("hold_done", 64'(all_done), 64'd1);
      chk("hold_out", {data_out1, data_out2}, first);
    end

    // Nonzero key and data.
    do_run(128'h6a1d78c88c86d67f2a65bfbeb4bd6e46, 32'h12345678, 32'h9abcdeff, edges);
    chk("k2_latency", 64'(edges), 64'(LATENCY));
    chk("k2_const", {data_out1, data_out2}, 64'h99bbb92b_3ebd1644);

    // Inputs are scrambled every cycle after the capture edge.
    key_in = 128'h6a1d78c88c86d67f2a65bfbeb4bd6e46; data_in1 = 32'h12345678; data_in2 = 32'h9abcdeff;
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    edge1();
    edge1();
    edges = 2;
    while (!all_done && edges < 200) begin
      key_in = {$urandom, $urandom, $urandom, $urandom};
      data_in1 = $urandom; data_in2 = $urandom;
      edge1();
      edges++;
    end
    chk("scramble_latency", 64'(edges), 64'(LATENCY));
    chk("scramble_out", {data_out1, data_out2}, 64'h99bbb92b_3ebd1644);

    // Abort at round 10, then start a fresh run.
    key_in = 128'h6a1d78c88c86d67f2a65bfbeb4bd6e46; data_in1 = 32'h12345678; data_in2 = 32'h9abcdeff;
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) edge1();
    #2 reset = 1'b1;
    #1;
    chk("abort_done", 64'(all_done), 64'd0);
    chk("abort_out", {data_out1, data_out2}, 64'd0);
    do_run(128'h62ee209f69b7afce376a8936cdc9e923, 32'h1, 32'h1, edges);
    chk("k3_latency", 64'(edges), 64'(LATENCY));
    chk("k3_const", {data_out1, data_out2}, 64'he57220dd_2622745b);
    chk("k3_model", {data_out1, data_out2}, xtea_ref(128'h62ee209f69b7afce376a8936cdc9e923, 1, 1));

    // all_done and the outputs must clear asynchronously, without waiting for a clock edge.
    #2 reset = 1'b1;
    #1;
    chk("async_done", 64'(all_done), 64'd0);
    chk("async_out", {data_out1, data_out2}, 64'd0);

    // Reset held for 5 cycles. Counting begins only at deassertion.
    key_in = 128'h11111111222222223333333344444444; data_in1 = 32'h0; data_in2 = 32'h0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk("held_done", 64'(all_done), 64'd0);
      chk("held_out", {data_out1, data_out2}, 64'd0);
    end
    reset = 1'b0;
    wait_done(0, edges);
    chk("held_latency", 64'(edges), 64'(LATENCY));
    chk("held_result", {data_out1, data_out2}, 64'hf07ac290_23c92672);

    // Random vectors checked against the reference model.
    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      ra = $urandom; rb = $urandom;
      exp = xtea_ref(rk, ra, rb);
      do_run(rk, ra, rb, edges);
      chk("rand_latency", 64'(edges), 64'(LATENCY));
      chk("rand_out", {data_out1, data_out2}, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xtea_encipher_core.md
Name: xtea_encipher_core

Overview:
- Iterative XTEA block-encipher engine: 64-bit plaintext (two 32-bit words) and 128-bit key in, 64-bit ciphertext out.
- Sits directly downstream of the cipher test/control sequencer. It consumes that sequencer's data_out_encipher1/2, key_out and reset_out, and returns data_in_encipher1/2 and all_done_encipher.
- Reset doubles as "start": each reset pulse launches one encipherment.
- One full XTEA cycle (two Feistel half-rounds) per clock.

Parameters:
- NUM_CYCLES, 32, number of XTEA cycles (64 Feistel rounds at default); legal range 1..63.
- DELTA, 32'h9E3779B9, key-schedule constant added to sum once per cycle.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears the engine; deassertion starts a new encipherment.
- data_in1  input  32  plaintext word v0.
- data_in2  input  32  plaintext word v1.
- key_in  input  128  key; k[0]=key_in[127:96], k[1]=[95:64], k[2]=[63:32], k[3]=[31:0].
- data_out1  output  32  ciphertext word v0; valid only while all_done=1.
- data_out2  output  32  ciphertext word v1; valid only while all_done=1.
- all_done  output  1  high when ciphertext is valid; held until next reset.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, cycle counter=0, sum=0.
  - data_out1=0, data_out2=0, all_done=0.
  - Any operation in progress is aborted; no partial result survives.
- States: IDLE -> LOAD -> ROUND -> DONE.
- IDLE:
  - Entered only via reset.
  - First rising edge with reset low moves to LOAD.
- LOAD (one cycle):
  - On its exiting edge, capture v0=data_in1, v1=data_in2, all four key words; sum=0; counter=0.
  - Inputs are sampled only at this edge; later changes are ignored.
- ROUND, on each edge:
  - v0' = v0 + ((((v1<<4) ^ (v1>>5)) + v1) ^ (sum + k[sum[1:0]]))
  - sum' = sum + DELTA
  - v1' = v1 + ((((v0'<<4) ^ (v0'>>5)) + v0') ^ (sum' + k[sum'[12:11]]))
  - Shifts are logical. All additions are modulo 2^32 (carries discarded).
  - counter increments; on the edge where counter reaches NUM_CYCLES-1, the final update is written and the state goes to DONE.
- DONE:
  - all_done=1; data_out1/2 hold the final v0/v1.
  - No further updates, whatever the inputs; stays until reset.
- Latency:
  - Edge 1 after reset deassertion: IDLE->LOAD.
  - Edge 2: capture.
  - Edges 3..NUM_CYCLES+2: rounds.
  - all_done rises after edge NUM_CYCLES+2 (34 at default).
- data_out1/2 may expose the working registers during ROUND. Consumers must qualify them with all_done.
- Back-to-back use: a new reset pulse of at least one cycle restarts from IDLE. No minimum gap after all_done is required.
- The counter is 6 bits, so it cannot wrap at legal NUM_CYCLES.
- sum wraps naturally modulo 2^32.
- Purely synchronous datapath apart from the async clear; no combinational path from inputs to outputs.

Test Plan:
- Key 0, data 00000000/00000000, one reset pulse -> all_done rises exactly 34 edges after reset falls; out=dee9d4d8/f7131ed9.
- Key 11111111222222223333333344444444, data 0/0 -> out=f07ac290/23c92672, all_done held high for 20 further cycles with outputs stable.
- Key 6a1d78c88c86d67f2a65bfbeb4bd6e46, data 12345678/9abcdeff -> 99bbb92b/3ebd1644.
- Change data_in/key_in every cycle after the LOAD edge, using the vector from the previous scenario -> result still 99bbb92b/3ebd1644 (inputs sampled only at LOAD).
- Assert reset at round 10 of a run, then start a new run with key 62ee209f69b7afce376a8936cdc9e923, data 00000001/00000001 -> all_done and outputs drop to 0 immediately (asynchronously); new result e57220dd/2622745b after 34 edges.
- Reset held high for 5 cycles -> all_done=0 and outputs=0 throughout; counting starts only at deassertion.
